// File: rtl/sb_rmw_ctrl.sv
// rtl/sb_rmw_ctrl.sv - store sequencer: sw write-through, sb read-modify-write via external wordmod.
// Optional misaligned-sw error state enabled by SB_RMW_MISALIGN_ERR_EN.
module sb_rmw_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_byte,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       wm_addr,
    output logic [31:0]       wm_orig_word,
    output logic [7:0]        wm_byte,
    input  logic [31:0]       wm_result
`ifdef SB_RMW_MISALIGN_ERR_EN
    ,
    output logic              misalign_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_MERGE = 3'd3,
        S_WRITE = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_RD_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [7:0]         byte_reg;
    logic [1:0]         lat_cnt;
    logic [31:0]        orig_reg;
    logic [ADDR_W-1:0]  wm_addr_reg;
    logic [7:0]         wm_byte_reg;
    logic               accept;
    logic               misalign_req;
    logic [ADDR_W-1:0]  aligned_addr;

    assign accept       = req_valid && req_ready;
    assign aligned_addr = {addr_reg[ADDR_W-1:2], 2'b00};

`ifdef SB_RMW_MISALIGN_ERR_EN
    assign misalign_req = !req_is_byte && (req_addr[1:0] != 2'b00);
`else
    assign misalign_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_is_byte) begin
                        state_nxt = S_READ;
                    end else if (misalign_req) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = (lat_cnt == 2'd0) ? S_MERGE : S_WAIT;
            S_MERGE: state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // wm_* registers load on the WAIT->MERGE edge so they are valid in MERGE and hold afterwards.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            byte_reg    <= '0;
            lat_cnt     <= '0;
            orig_reg    <= '0;
            wm_addr_reg <= '0;
            wm_byte_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                byte_reg  <= req_byte;
            end
            case (state)
                S_READ: lat_cnt <= LAT_INIT;
                S_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        orig_reg    <= mem_rdata;
                        wm_addr_reg <= addr_reg;
                        wm_byte_reg <= byte_reg;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_MERGE: wdata_reg <= wm_result;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
`ifdef SB_RMW_MISALIGN_ERR_EN
        misalign_err = 1'b0;
`endif
        case (state)
            S_IDLE: req_ready = nrst;
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = aligned_addr;
            end
            S_WAIT: mem_addr = aligned_addr;
            S_WRITE: begin
                mem_wr_en = 1'b1;
                mem_addr  = aligned_addr;
                mem_wdata = wdata_reg;
                done      = 1'b1;
            end
`ifdef SB_RMW_MISALIGN_ERR_EN
            S_ERR: misalign_err = 1'b1;
`endif
            default: ;
        endcase
    end

    assign wm_addr      = 32'(wm_addr_reg);
    assign wm_orig_word = orig_reg;
    assign wm_byte      = wm_byte_reg;

endmodule

// File: doc/sb_rmw_ctrl.md
Name: sb_rmw_ctrl

Overview:
Store-path sequencer between the datapath store request and the word-wide data memory.
- Word stores (sw): written straight through.
- Byte stores (sb): read-modify-write. The block reads the aligned word, hands address, original word and byte to the external wordmod merge block, captures the merged word, and writes it back.
- Stalls the CPU via req_ready while a store is in flight.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory word width (fixed 32 for wordmod compatibility).
- MEM_RD_LAT, 1, cycles from mem_rd_en to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  synchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_is_byte  in  1  1 = sb, 0 = sw.
- req_addr  in  ADDR_W  byte address of store.
- req_wdata  in  DATA_W  sw data.
- req_byte  in  8  sb data.
- done  out  1  one-cycle pulse, store committed.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_rd_en  out  1  read strobe.
- mem_rdata  in  DATA_W  read data.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  DATA_W  write data.
- wm_addr  out  32  to wordmod addr.
- wm_orig_word  out  32  to wordmod original word.
- wm_byte  out  8  to wordmod byte to write.
- wm_result  in  32  merged word from wordmod (combinational).

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous, active-low.
- Reset values (state on nrst=0 at an edge):
  - state=IDLE.
  - All registers 0.
  - req_ready=0 while nrst=0.
  - done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, wm_* = 0.
- Acceptance: a request is accepted on an edge where req_valid && req_ready.
  - req_addr, req_is_byte, req_wdata and req_byte are captured into registers.
  - Inputs are ignored when not accepted.
- req_ready=1 only in IDLE (and not in reset).
- States and per-state outputs (outputs are decoded from the state register plus captured registers, not from req_*):
  - IDLE: wait for acceptance. sb goes to READ; sw goes to WRITE.
  - READ (1 cycle): mem_rd_en=1, mem_addr={addr[ADDR_W-1:2],2'b00}. Load lat_cnt=MEM_RD_LAT-1. Go to WAIT.
  - WAIT: hold mem_addr. If lat_cnt==0, capture mem_rdata into orig_reg and go to MERGE; else decrement lat_cnt.
  - MERGE (1 cycle): wm_addr=addr_reg, wm_orig_word=orig_reg, wm_byte=byte_reg. Capture wm_result into wdata_reg. Go to WRITE.
  - WRITE (1 cycle): mem_wr_en=1, mem_addr aligned, mem_wdata=wdata_reg (sw: the captured req_wdata). done=1. Go to IDLE.
- Latency from the acceptance edge T:
  - sw: write and done in cycle T+1; next accept possible at T+2.
  - sb: READ at T+1, WAIT for MEM_RD_LAT cycles, MERGE, WRITE at T+3+MEM_RD_LAT.
- Back-to-back: req_valid held high gives one accept per IDLE visit. There are no dropped or duplicated writes.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- wm_* outputs hold their last values outside MERGE. Their reset value is 0.
- Reset mid-operation: nrst=0 at any edge returns to IDLE.
  - No mem_wr_en or done in the following cycle.
  - The aborted store is lost; the upstream reissues it.
- sw with addr[1:0]!=0: aligned write of req_wdata, low bits dropped (default build).

Optional Feature:
- Macro: SB_RMW_MISALIGN_ERR_EN.
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - An accepted sw with req_addr[1:0]!=0 goes IDLE->ERR->IDLE. ERR lasts 1 cycle with misalign_err=1, mem_wr_en=0 and done=0.
  - sb is unaffected.
- Undefined: port absent; misaligned sw behaves as stated above.

Test Plan:
- Reset: nrst=0 for 2 cycles with req_valid=1 -> req_ready=0, mem_wr_en=0, done=0. First cycle after nrst=1: req_ready=1.
- sw: addr=0x81234560, wdata=0xDEADBEEF, accepted at T -> at T+1: mem_wr_en=1, mem_addr=0x81234560, mem_wdata=0xDEADBEEF, done=1. At T+2: req_ready=1.
- sb, MEM_RD_LAT=1: addr=0x81234561, byte=0xFF, memory returns 0xAAAAAAAA, wm_result stub returns 0x12345678 ->
  - T+1: mem_rd_en=1, mem_addr=0x81234560.
  - T+3: wm_addr=0x81234561, wm_orig_word=0xAAAAAAAA, wm_byte=0xFF.
  - T+4: mem_wr_en=1, mem_wdata=0x12345678, done=1.
- sb, MEM_RD_LAT=3: same stimulus -> write at T+6; mem_rdata sampled only at T+4, and garbage at T+2..T+3 is ignored.
- Reset mid-sb: nrst=0 during WAIT -> no mem_wr_en afterwards. After release, an sw to 0x00000004 completes normally.
- SB_RMW_MISALIGN_ERR_EN defined: sw addr=0x00000006 -> misalign_err=1 for one cycle, no write, req_ready=1 two cycles after accept.
